// File: rtl/cnt_down.sv
// HH:MM:SS countdown timer with prescaled one-second tick and 7-seg outputs.
// Optional latched alarm output enabled by defining CNT_DOWN_ALARM_EN.
module cnt_down #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] load_h,
    input  logic [5:0] load_m,
    input  logic [5:0] load_s,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    output logic [5:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       done,
    output logic [7:0] HEX00,
    output logic [7:0] HEX01,
    output logic [7:0] HEX02,
    output logic [7:0] HEX03,
    output logic [7:0] HEX04,
    output logic [7:0] HEX05,
    output logic       alarm,
    input  logic       alarm_ack
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    h_d, m_d, s_d;
    logic          done_d;

    function automatic logic [5:0] sat(input logic [5:0] v, input logic [5:0] max);
        return (v > max) ? max : v;
    endfunction

    function automatic logic [6:0] seg7(input logic [5:0] d);
        case (d)
            6'd0:    return 7'b1000000;
            6'd1:    return 7'b1111001;
            6'd2:    return 7'b0100100;
            6'd3:    return 7'b0110000;
            6'd4:    return 7'b0011001;
            6'd5:    return 7'b0010010;
            6'd6:    return 7'b0000010;
            6'd7:    return 7'b1111000;
            6'd8:    return 7'b0000000;
            6'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // State, prescaler, time and done pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            hours   <= '0;
            minutes <= '0;
            seconds <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hours   <= h_d;
            minutes <= m_d;
            seconds <= s_d;
            done    <= done_d;
        end
    end

    // Next-state: load beats stop beats start; time moves only on load or tick
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        h_d     = hours;
        m_d     = minutes;
        s_d     = seconds;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            presc_d = '0;
            h_d     = sat(load_h, 6'd23);
            m_d     = sat(load_m, 6'd59);
            s_d     = sat(load_s, 6'd59);
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && start &&
                        (hours != 6'd0 || minutes != 6'd0 || seconds != 6'd0))
                        state_d = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == TOP) begin
                        presc_d = '0;
                        if (seconds != 6'd0) begin
                            s_d = seconds - 6'd1;
                        end else if (minutes != 6'd0) begin
                            s_d = 6'd59;
                            m_d = minutes - 6'd1;
                        end else begin
                            s_d = 6'd59;
                            m_d = 6'd59;
                            h_d = hours - 6'd1;
                        end
                        if (hours == 6'd0 && minutes == 6'd0 && seconds == 6'd1) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (start && !stop)
                        state_d = RUN;
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign running = (state_q == RUN);

    // Display decode straight from the time registers
    always_comb begin
        HEX00 = {1'b1, seg7(hours / 6'd10)};
        HEX01 = {1'b1, seg7(hours % 6'd10)};
        HEX02 = {1'b1, seg7(minutes / 6'd10)};
        HEX03 = {1'b1, seg7(minutes % 6'd10)};
        HEX04 = {1'b1, seg7(seconds / 6'd10)};
        HEX05 = {1'b1, seg7(seconds % 6'd10)};
    end

`ifdef CNT_DOWN_ALARM_EN
    logic alarm_q;

    // Alarm latches on expiry; set wins over a same-cycle acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            alarm_q <= 1'b0;
        else if (done_d)
            alarm_q <= 1'b1;
        else if (alarm_ack || load)
            alarm_q <= 1'b0;
    end

    assign alarm = alarm_q;
`else
    logic unused_alarm_ack;

    assign unused_alarm_ack = alarm_ack;
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_down.sv
// Directed self-checking bench for cnt_down with TICK_DIV=4.
// Alarm expectations follow CNT_DOWN_ALARM_EN.
module tb_cnt_down;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] load_h = '0;
    logic [5:0] load_m = '0;
    logic [5:0] load_s = '0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       alarm_ack = 1'b0;
    logic [5:0] hours, minutes, seconds;
    logic       running, done, alarm;
    logic [7:0] HEX00, HEX01, HEX02, HEX03, HEX04, HEX05;

    int ncmp = 0;
    int nerr = 0;

`ifdef CNT_DOWN_ALARM_EN
    localparam logic ALM = 1'b1;
`else
    localparam logic ALM = 1'b0;
`endif

    cnt_down #(.TICK_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .load_h(load_h),
        .load_m(load_m),
        .load_s(load_s),
        .load(load),
        .start(start),
        .stop(stop),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .running(running),
        .done(done),
        .HEX00(HEX00),
        .HEX01(HEX01),
        .HEX02(HEX02),
        .HEX03(HEX03),
        .HEX04(HEX04),
        .HEX05(HEX05),
        .alarm(alarm),
        .alarm_ack(alarm_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tchk(input string tag, input logic [5:0] h, input logic [5:0] m,
                        input logic [5:0] s);
        chk(tag, {hours, minutes, seconds}, {h, m, s});
    endtask

    task automatic hexchk(input string tag, input logic [47:0] e);
        chk(tag, {HEX00, HEX01, HEX02, HEX03, HEX04, HEX05}, e);
    endtask

    task automatic rst_chk(input string tag);
        tchk({tag, "_time"}, 6'd0, 6'd0, 6'd0);
        chk({tag, "_run"}, running, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_alarm"}, alarm, 1'b0);
        hexchk({tag, "_hex"}, 48'hC0C0_C0C0_C0C0);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        load_h = h;
        load_m = m;
        load_s = s;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        // power-on reset, checked before any clock edge
        #1 rst = 1'b0;
        #2 rst_chk("por");
        cyc();
        rst = 1'b1;
        cyc();
        chk("por_idle", running, 1'b0);

        // 00:00:03 expires 12 cycles after start
        do_load(6'd0, 6'd0, 6'd3);
        tchk("t1_load", 6'd0, 6'd0, 6'd3);
        chk("t1_idle0", running, 1'b0);
        do_start();
        chk("t1_run", running, 1'b1);
        chk("t1_done0", done, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("t1_done", done, (k == 12));
            tchk("t1_cnt", 6'd0, 6'd0, 6'(3 - k / 4));
        end
        chk("t1_stopped", running, 1'b0);
        cyc();
        chk("t1_done1", done, 1'b0);
        do_start();
        chk("t1_exp_start", running, 1'b0);
        tchk("t1_exp_time", 6'd0, 6'd0, 6'd0);
        chk("t1_exp_done", done, 1'b0);

        // borrow across hours/minutes
        do_load(6'd1, 6'd0, 6'd0);
        do_start();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k < 4)
                tchk("t2_hold", 6'd1, 6'd0, 6'd0);
            else
                tchk("t2_borrow", 6'd0, 6'd59, 6'd59);
        end
        hexchk("t2_hex", 48'hC0C0_9290_9290);
        do_stop();
        chk("t2_pause", running, 1'b0);

        // pause with prescaler at 2, resume ticks two cycles later
        do_load(6'd0, 6'd0, 6'd5);
        do_start();
        cyc();
        cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t3_paused", running, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            tchk("t3_hold", 6'd0, 6'd0, 6'd5);
        end
        do_stop();
        chk("t3_stop_ign", running, 1'b0);
        do_start();
        chk("t3_resume", running, 1'b1);
        tchk("t3_r0", 6'd0, 6'd0, 6'd5);
        cyc();
        tchk("t3_r1", 6'd0, 6'd0, 6'd5);
        cyc();
        tchk("t3_r2", 6'd0, 6'd0, 6'd4);
        do_start();
        chk("t3_start_in_run", running, 1'b1);

        // saturation and start at zero
        do_load(6'd63, 6'd63, 6'd63);
        tchk("t4_sat", 6'd23, 6'd59, 6'd59);
        hexchk("t4_hex", 48'hA4B0_9290_9290);
        do_load(6'd0, 6'd0, 6'd0);
        do_start();
        chk("t4_zero_start", running, 1'b0);
        cyc();
        chk("t4_zero_idle", running, 1'b0);

        // load+stop+start together in RUN
        do_load(6'd0, 6'd0, 6'd9);
        do_start();
        cyc();
        cyc();
        load_h = 6'd0;
        load_m = 6'd2;
        load_s = 6'd7;
        load = 1'b1;
        stop = 1'b1;
        start = 1'b1;
        cyc();
        load = 1'b0;
        stop = 1'b0;
        start = 1'b0;
        chk("t5_idle", running, 1'b0);
        tchk("t5_time", 6'd0, 6'd2, 6'd7);
        do_start();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            tchk("t5_presc0", 6'd0, 6'd2, (k < 4) ? 6'd7 : 6'd6);
        end

        // alarm: set with coincident ack, then ack, then load clear
        do_load(6'd0, 6'd0, 6'd1);
        chk("a_clr_load", alarm, 1'b0);
        do_start();
        cyc();
        cyc();
        cyc();
        alarm_ack = 1'b1;
        cyc();
        alarm_ack = 1'b0;
        chk("a_done", done, 1'b1);
        chk("a_set", alarm, ALM);
        tchk("a_zero", 6'd0, 6'd0, 6'd0);
        cyc();
        chk("a_hold", alarm, ALM);
        chk("a_done_end", done, 1'b0);
        alarm_ack = 1'b1;
        cyc();
        alarm_ack = 1'b0;
        chk("a_ack", alarm, 1'b0);
        do_load(6'd0, 6'd0, 6'd1);
        do_start();
        for (int k = 0; k < 4; k++) cyc();
        chk("a_set2", alarm, ALM);
        do_load(6'd0, 6'd0, 6'd2);
        chk("a_load_clr", alarm, 1'b0);

        // asynchronous reset mid-RUN, between clock edges
        do_start();
        for (int k = 0; k < 5; k++) cyc();
        chk("r_running", running, 1'b1);
        #2 rst = 1'b0;
        #1 rst_chk("rst_run");
        cyc();
        rst = 1'b1;
        cyc();
        chk("r_idle1", running, 1'b0);
        cyc();
        chk("r_idle2", running, 1'b0);
        tchk("r_time", 6'd0, 6'd0, 6'd0);

        // reset clears a latched alarm
        do_load(6'd0, 6'd0, 6'd1);
        do_start();
        for (int k = 0; k < 4; k++) cyc();
        chk("r_alm_set", alarm, ALM);
        #2 rst = 1'b0;
        #1 rst_chk("rst_alm");
        cyc();
        rst = 1'b1;
        cyc();
        chk("r_alm_idle", running, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/cnt_down.md
CNT_DOWN -- requirements
Module: cnt_down

Interface
REQ-001 The module SHALL expose parameter TICK_DIV, default 50000000: clk cycles per one-second tick; legal range 2 to 67108863.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock at 50 MHz.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports load_h, load_m and load_s, inputs, 6 bits each: binary preset for hours, minutes and seconds.
REQ-005 The module SHALL have port load, input, 1 bit: single-cycle pulse that captures the preset.
REQ-006 The module SHALL have ports start and stop, inputs, 1 bit each: single-cycle pulses that start or resume, and pause, the countdown.
REQ-007 The module SHALL have ports hours, minutes and seconds, outputs, 6 bits each: current remaining time in binary.
REQ-008 The module SHALL have port running, output, 1 bit: high while in RUN.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse on expiry.
REQ-010 The module SHALL have ports HEX00 to HEX05, outputs, 8 bits each: hours tens/units, minutes tens/units, seconds tens/units, in that order; bit 7 is the decimal point, bits 6:0 are segments gfedcba, all active-low.
REQ-011 The module SHALL have ports alarm (output, 1 bit) and alarm_ack (input, 1 bit), present only as described under Configuration.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, PAUSE and EXPIRED, plus a prescaler counter 0..TICK_DIV-1.
REQ-013 When several controls are asserted in the same cycle, the priority SHALL be load > stop > start.
REQ-014 Load, in any state, SHALL register the preset on the next edge, clear the prescaler and enter IDLE.
REQ-015 Load SHALL saturate load_s and load_m above 59 to 59, and load_h above 23 to 23.
REQ-016 In IDLE, start with a nonzero time SHALL enter RUN; start with time 00:00:00 SHALL be ignored.
REQ-017 In RUN, the prescaler SHALL increment every cycle; on reaching TICK_DIV-1 it SHALL wrap to 0 and issue one tick in that cycle.
REQ-018 On a tick, the counter SHALL apply one decrement with borrow:
- s>0: s-1.
- s=0, m>0: s=59, m-1.
- s=0, m=0: s=59, m=59, h-1.
REQ-019 When a tick produces 00:00:00, the FSM SHALL enter EXPIRED and assert done for exactly that one cycle, coincident with the registers reading zero.
REQ-020 In RUN, stop SHALL enter PAUSE; the prescaler SHALL hold its value, and no tick SHALL occur in that cycle.
REQ-021 In PAUSE, start SHALL return to RUN, resuming the prescaler from its held value; stop SHALL be ignored.
REQ-022 In EXPIRED, time SHALL remain 00:00:00, start and stop SHALL be ignored, and only load SHALL exit the state.
REQ-023 Start received while already in RUN SHALL have no effect.
REQ-024 The time registers SHALL change only on load or on a tick.
REQ-025 HEX00 to HEX05 SHALL be combinational decodes of the registered time, valid in the same cycle.
REQ-026 The digit split SHALL be tens = value/10 and units = value%10.
REQ-027 Each HEX decimal point SHALL be 1 (off).
REQ-028 The digit patterns SHALL be (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-029 Asserting rst low SHALL immediately enter IDLE, regardless of the current state or an in-progress tick.
REQ-030 On reset, hours, minutes, seconds and the prescaler SHALL clear to 0, and running, done and alarm SHALL be 0.
REQ-031 During reset, HEX00 to HEX05 SHALL show 0 (8'hC0).
REQ-032 On rst deassertion, the module SHALL remain in IDLE until start.

Configuration
REQ-033 With macro CNT_DOWN_ALARM_EN defined, the module SHALL include the alarm port and the alarm_ack port.
REQ-034 With CNT_DOWN_ALARM_EN defined, alarm SHALL be set in the same cycle as done and stay high until alarm_ack or load; a simultaneous done and alarm_ack SHALL leave alarm set.
REQ-035 With CNT_DOWN_ALARM_EN undefined, the alarm port SHALL be driven constant 0, alarm_ack SHALL be ignored, and no alarm register SHALL be generated.

Verification
REQ-036 The bench SHALL cover, with TICK_DIV=4, load 00:00:03 then start: done SHALL pulse exactly 12 cycles after start is sampled, and running SHALL then be 0.
REQ-037 The bench SHALL cover borrow with load 01:00:00 and run to one tick: the time SHALL read 00:59:59, and HEX00 to HEX05 SHALL read C0 C0 92 90 92 90.
REQ-038 The bench SHALL cover pause with stop after 2 prescaler cycles, a 10-cycle wait, then start: the first tick SHALL occur 2 cycles after resume, and the time SHALL be unchanged during PAUSE.
REQ-039 The bench SHALL cover saturation with load 63:63:63: the time SHALL read 23:59:59, and start at 00:00:00 SHALL keep the FSM in IDLE.
REQ-040 The bench SHALL cover priority with load, stop and start in the same cycle while in RUN: the FSM SHALL load and be in IDLE, with the prescaler at 0.
REQ-041 The bench SHALL cover reset mid-RUN at an arbitrary cycle: all outputs SHALL reach reset values without a clock edge; with CNT_DOWN_ALARM_EN defined, a latched alarm SHALL clear on reset and on alarm_ack.
